alu_issue_ctrl: RTL and testbench

//  Initiator side of the ALU interface. Accepts register-form instructions over a

---
 rtl/alu_issue_ctrl_if.sv | 45 ++++
 rtl/alu_issue_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// alu_issue_ctrl_if
// Purpose : bundles the two valid/ready channels of the ALU issue controller.
//           The instruction channel carries {opcode, rd, ra, rb} into the
//           controller. The result channel returns {rd, data} to the host.
// Signals :
//   instr_valid / instr_ready / instr      instruction channel (host -> ctrl)
//   res_valid / res_ready / res_rd / res_data  result channel (ctrl -> host)
// Modports:
//   slave  : the issue controller (accepts instructions, offers results)
//   master : the host side (offers instructions, consumes results)
// ---------------------------------------------------------------------------
interface alu_issue_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 3
);
    logic                     instr_valid;
    logic                     instr_ready;
    logic [3+3*REG_AW-1:0]    instr;
    logic                     res_valid;
    logic                     res_ready;
    logic [REG_AW-1:0]        res_rd;
    logic [DATA_W-1:0]        res_data;

    modport slave (
        input  instr_valid,
        output instr_ready,
        input  instr,
        output res_valid,
        input  res_ready,
        output res_rd,
        output res_data
    );

    modport master (
        output instr_valid,
        input  instr_ready,
        output instr,
        input  res_valid,
        output res_ready,
        input  res_rd,
        input  res_data
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// alu_issue_ctrl
// Purpose : initiator side of a combinational ALU. Accepts register-form
//           instructions, reads operands from an internal register file,
//           drives the ALU, writes the result back, keeps zero/carry flags and
//           returns every result over a valid/ready channel.
// Ports   :
//   clk, rst_n                 clock (rising edge), async active-low reset
//   bus (slave modport)        instruction and result handshake channels
//   alu_a, alu_b, alu_opcode   operands/opcode to the external ALU
//   alu_out, alu_zero, alu_carry  combinational ALU response
//   ld_en, ld_addr, ld_data    host register load (any state, any edge)
//   dbg_addr, dbg_data         combinational debug read of the register file
//   flag_zero, flag_carry      flags of the last executed operation
// Flow    : IDLE (accept) -> EXEC (ALU evaluates, writeback) -> WB (offer result)
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_issue_ctrl_if.slave      bus,
    output logic [DATA_W-1:0]    alu_a,
    output logic [DATA_W-1:0]    alu_b,
    output logic [2:0]           alu_opcode,
    input  logic [DATA_W-1:0]    alu_out,
    input  logic                 alu_zero,
    input  logic                 alu_carry,
    input  logic                 ld_en,
    input  logic [REG_AW-1:0]    ld_addr,
    input  logic [DATA_W-1:0]    ld_data,
    input  logic [REG_AW-1:0]    dbg_addr,
    output logic [DATA_W-1:0]    dbg_data,
    output logic                 flag_zero,
    output logic                 flag_carry
);

    localparam int NREGS   = 2**REG_AW;
    localparam int INSTR_W = 3 + 3*REG_AW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [REG_AW-1:0]    res_rd_q, res_rd_d;
    logic [DATA_W-1:0]    res_data_q, res_data_d;
    logic                 flag_zero_q, flag_zero_d;
    logic                 flag_carry_q, flag_carry_d;
    logic [DATA_W-1:0]    alu_a_q, alu_a_d;
    logic [DATA_W-1:0]    alu_b_q, alu_b_d;
    logic [2:0]           alu_opcode_q, alu_opcode_d;

    // Fields of the latched instruction
    logic [2:0]           dec_op;
    logic [REG_AW-1:0]    dec_rd;
    logic [REG_AW-1:0]    dec_ra;
    logic [REG_AW-1:0]    dec_rb;

    assign dec_op = instr_q[INSTR_W-1 -: 3];
    assign dec_rd = instr_q[3*REG_AW-1 -: REG_AW];
    assign dec_ra = instr_q[2*REG_AW-1 -: REG_AW];
    assign dec_rb = instr_q[REG_AW-1:0];

    logic in_exec;
    logic wb_en;

    assign in_exec = (state_q == ST_EXEC);
    // Writes to r0 are dropped simply by never enabling them
    assign wb_en   = in_exec && (dec_rd != '0);

    // ------------------------------------------------------------------
    // Register file: one flop word per entry, r0 tied to zero.
    // Writeback is applied after the host load so it wins on a collision.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rf_rd [NREGS];

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_rf
            if (gi == 0) begin : g_zero
                assign rf_rd[gi] = '0;
            end else begin : g_reg
                localparam logic [REG_AW-1:0] IDX = REG_AW'(gi);
                logic [DATA_W-1:0] word_q, word_d;

                always_comb begin
                    word_d = word_q;
                    if (ld_en && (ld_addr == IDX)) begin
                        word_d = ld_data;
                    end
                    if (wb_en && (dec_rd == IDX)) begin
                        word_d = alu_out;
                    end
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        word_q <= '0;
                    end else begin
                        word_q <= word_d;
                    end
                end

                assign rf_rd[gi] = word_q;
            end
        end
    endgenerate

    assign dbg_data = rf_rd[dbg_addr];

    // ------------------------------------------------------------------
    // ALU drive: live register-file operands during EXEC, otherwise the
    // values last presented are held so the ALU inputs do not toggle.
    // ------------------------------------------------------------------
    always_comb begin
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_opcode_d = alu_opcode_q;
        if (in_exec) begin
            alu_a_d      = rf_rd[dec_ra];
            alu_b_d      = rf_rd[dec_rb];
            alu_opcode_d = dec_op;
        end
    end

    assign alu_a      = alu_a_d;
    assign alu_b      = alu_b_d;
    assign alu_opcode = alu_opcode_d;

    // ------------------------------------------------------------------
    // Control FSM: next state, captures and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        instr_d         = instr_q;
        res_rd_d        = res_rd_q;
        res_data_d      = res_data_q;
        flag_zero_d     = flag_zero_q;
        flag_carry_d    = flag_carry_q;
        // Ready is masked by rst_n so nothing looks accepted while held in reset
        bus.instr_ready = 1'b0;
        bus.res_valid   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                bus.instr_ready = rst_n;
                if (bus.instr_valid) begin
                    instr_d = bus.instr;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_data_d   = alu_out;
                res_rd_d     = dec_rd;
                flag_zero_d  = alu_zero;
                flag_carry_d = alu_carry;
                state_d      = ST_WB;
            end
            ST_WB: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            instr_q      <= '0;
            res_rd_q     <= '0;
            res_data_q   <= '0;
            flag_zero_q  <= 1'b0;
            flag_carry_q <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_opcode_q <= '0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            res_rd_q     <= res_rd_d;
            res_data_q   <= res_data_d;
            flag_zero_q  <= flag_zero_d;
            flag_carry_q <= flag_carry_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_opcode_q <= alu_opcode_d;
        end
    end

    assign bus.res_rd   = res_rd_q;
    assign bus.res_data = res_data_q;
    assign flag_zero    = flag_zero_q;
    assign flag_carry   = flag_carry_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
// Directed bench for alu_issue_ctrl with a small behavioural ALU attached.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;

    localparam int DATA_W = 8;
    localparam int REG_AW = 3;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] alu_a, alu_b, alu_out;
    logic [2:0]        alu_opcode;
    logic              alu_zero, alu_carry;
    logic              ld_en;
    logic [REG_AW-1:0] ld_addr, dbg_addr;
    logic [DATA_W-1:0] ld_data, dbg_data;
    logic              flag_zero, flag_carry;

    int errors = 0;
    int checks = 0;

    alu_issue_ctrl_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

    alu_issue_ctrl #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_out    (alu_out),
        .alu_zero   (alu_zero),
        .alu_carry  (alu_carry),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: carry only produced by add
    logic [DATA_W:0] sum;
    always_comb begin
        sum       = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out   = '0;
        alu_carry = 1'b0;
        case (alu_opcode)
            3'd0: begin alu_out = sum[DATA_W-1:0]; alu_carry = sum[DATA_W]; end
            3'd1: alu_out = alu_a - alu_b;
            3'd2: alu_out = alu_a & alu_b;
            3'd3: alu_out = alu_a | alu_b;
            3'd4: alu_out = alu_a ^ alu_b;
            3'd5: alu_out = ~alu_a;
            3'd6: alu_out = alu_a << 1;
            default: alu_out = alu_a >> 1;
        endcase
        alu_zero = (alu_out == '0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_dbg(input string tag, input int addr, input logic [31:0] exp);
        dbg_addr = REG_AW'(addr);
        #1;
        check(tag, 32'(dbg_data), exp);
    endtask

    function automatic logic [3+3*REG_AW-1:0] mk(input int op, input int rd, input int ra, input int rb);
        return {op[2:0], rd[REG_AW-1:0], ra[REG_AW-1:0], rb[REG_AW-1:0]};
    endfunction

    task automatic ld(input int addr, input int data);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = REG_AW'(addr);
        ld_data = DATA_W'(data);
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    // Offers one instruction; returns at the falling edge inside EXEC
    task automatic issue(input int op, input int rd, input int ra, input int rb);
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr       = mk(op, rd, ra, rb);
        @(negedge clk);
        bus.instr_valid = 1'b0;
    endtask

    // Called from WB; returns at the falling edge after the result handshake
    task automatic retire(input string tag);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(bus.res_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(bus.instr_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        rst_n           = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.res_ready   = 1'b0;
        ld_en           = 1'b0;
        ld_addr         = '0;
        ld_data         = '0;
        dbg_addr        = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_instr_ready", 32'(bus.instr_ready), 32'd0);
        check("rst_res_valid",   32'(bus.res_valid),   32'd0);
        check("rst_alu_a",       32'(alu_a),           32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_instr_ready", 32'(bus.instr_ready), 32'd1);

        // 1: add with carry
        ld(1, 'hF0);
        ld(2, 'h20);
        ld(4, 'h77);
        check_dbg("ld_r1", 1, 32'hF0);
        check_dbg("ld_r4", 4, 32'h77);
        issue(0, 3, 1, 2);
        check("t1_exec_valid", 32'(bus.res_valid),   32'd0);
        check("t1_exec_ready", 32'(bus.instr_ready), 32'd0);
        check("t1_alu_a",      32'(alu_a),           32'hF0);
        check("t1_alu_b",      32'(alu_b),           32'h20);
        check("t1_alu_op",     32'(alu_opcode),      32'd0);
        @(negedge clk);
        check("t1_wb_valid",   32'(bus.res_valid),   32'd1);
        check("t1_res_data",   32'(bus.res_data),    32'h10);
        check("t1_res_rd",     32'(bus.res_rd),      32'd3);
        check("t1_carry",      32'(flag_carry),      32'd1);
        check("t1_zero",       32'(flag_zero),       32'd0);
        check_dbg("t1_dbg_r3", 3, 32'h10);
        retire("t1");

        // 2: sub to zero, overwriting a nonzero register
        issue(1, 4, 1, 1);
        @(negedge clk);
        check("t2_res_data",   32'(bus.res_data),    32'h00);
        check("t2_zero",       32'(flag_zero),       32'd1);
        check("t2_carry",      32'(flag_carry),      32'd0);
        check("t2_op_held",    32'(alu_opcode),      32'd1);
        check_dbg("t2_dbg_r4", 4, 32'h00);
        retire("t2");

        // 3: result to r0 is reported but not stored
        issue(3, 0, 1, 2);
        @(negedge clk);
        check("t3_res_rd",     32'(bus.res_rd),      32'd0);
        check("t3_res_data",   32'(bus.res_data),    32'hF0);
        check_dbg("t3_dbg_r0", 0, 32'h00);
        retire("t3");

        // 4: backpressure with a pending instruction
        issue(4, 5, 1, 2);
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr       = mk(2, 6, 1, 2);
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_valid", 32'(bus.res_valid),   32'd1);
            check("t4_hold_data",  32'(bus.res_data),    32'hD0);
            check("t4_hold_rd",    32'(bus.res_rd),      32'd5);
            check("t4_hold_ready", 32'(bus.instr_ready), 32'd0);
            @(negedge clk);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check("t4_idle_ready", 32'(bus.instr_ready), 32'd1);
        check("t4_idle_valid", 32'(bus.res_valid),   32'd0);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        check("t4_next_exec",  32'(bus.instr_ready), 32'd0);
        check("t4_next_op",    32'(alu_opcode),      32'd2);
        @(negedge clk);
        check("t4_next_data",  32'(bus.res_data),    32'h20);
        check("t4_next_rd",    32'(bus.res_rd),      32'd6);
        check_dbg("t4_dbg_r5", 5, 32'hD0);
        retire("t4");

        // shift left: no carry reported
        issue(6, 7, 1, 0);
        check("shl_alu_b",     32'(alu_b),           32'd0);
        @(negedge clk);
        check("shl_res_data",  32'(bus.res_data),    32'hE0);
        check("shl_carry",     32'(flag_carry),      32'd0);
        retire("shl");

        // 5: load and writeback collide on r3; load during WB still lands
        ld(5, 'h35);
        issue(0, 3, 5, 2);
        ld_en   = 1'b1;
        ld_addr = 3'd3;
        ld_data = 8'hAA;
        @(negedge clk);
        ld_addr = 3'd7;
        ld_data = 8'h12;
        check("t5_res_data",   32'(bus.res_data),    32'h55);
        @(negedge clk);
        ld_en = 1'b0;
        check_dbg("t5_dbg_r3", 3, 32'h55);
        check_dbg("t5_dbg_r7", 7, 32'h12);
        retire("t5");

        // 6: reset in the middle of EXEC
        issue(1, 4, 1, 1);
        @(negedge clk);
        check("t6_pre_zero",   32'(flag_zero),       32'd1);
        retire("t6pre");
        issue(0, 3, 1, 2);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid",  32'(bus.res_valid),   32'd0);
        check("t6_rst_ready",  32'(bus.instr_ready), 32'd0);
        check("t6_rst_zero",   32'(flag_zero),       32'd0);
        check("t6_rst_carry",  32'(flag_carry),      32'd0);
        check("t6_rst_data",   32'(bus.res_data),    32'd0);
        check("t6_rst_rd",     32'(bus.res_rd),      32'd0);
        check("t6_rst_alu_a",  32'(alu_a),           32'd0);
        check("t6_rst_alu_op", 32'(alu_opcode),      32'd0);
        for (int a = 0; a < 8; a++) begin
            check_dbg("t6_rst_reg", a, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t6_rel_ready",  32'(bus.instr_ready), 32'd1);
        repeat (3) begin
            @(negedge clk);
            check("t6_no_stale", 32'(bus.res_valid), 32'd0);
        end

        // Normal operation after reset: not
        ld(1, 'h05);
        issue(5, 2, 1, 0);
        @(negedge clk);
        check("post_res_data", 32'(bus.res_data),    32'hFA);
        check("post_zero",     32'(flag_zero),       32'd0);
        retire("post");
        check_dbg("post_dbg_r2", 2, 32'hFA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
